// File: rtl/pc8001m_pkg.sv
// pc8001m_pkg: boot sequencer state enum, OSD switch bit indices and the default reset-only switch mask
package pc8001m_pkg;
  typedef enum logic [1:0] {S_HOLD, S_LOAD, S_DRAIN, S_RUN} boot_state_t;
  localparam int SW_GREEN = 0;
  localparam int SW_BEEP = 2;
  localparam int SW_FDC = 3;
  localparam int SW_CPU = 4;
  localparam int SW_PCG = 5;
  localparam int SW_EXPROM = 7;
  localparam int SW_HISPEED = 9;
  localparam logic [9:0] RST_MASK_DEF = 10'((1 << SW_HISPEED) | (1 << SW_CPU));
endpackage

// File: rtl/pc8001m_wbuf.sv
// pc8001m_wbuf: one-entry ROM write buffer; in clk/rst/i_load/i_addr/i_data/i_ready, out o_full (doubles as write request)/o_addr/o_data
module pc8001m_wbuf #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_data,
  input  logic          i_ready,
  output logic          o_full,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_data
);
  logic          r_full;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_data;
  always_ff @(posedge clk)
    if (rst) begin
      r_full <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_load && !r_full) begin
      r_full <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (r_full && i_ready) r_full <= 1'b0;
  assign o_full = r_full;
  assign o_addr = r_addr;
  assign o_data = r_data;
endmodule

// File: rtl/pc8001m_boot_ctrl.sv
// pc8001m_boot_ctrl: ROM download streaming, core reset hold and reset-only switch gating; ioctl_* in/ioctl_wait out, status_sw in/switch_out out, rom_* write port, core_reset/rom_valid/load_err out
module pc8001m_boot_ctrl
  import pc8001m_pkg::*;
#(
  parameter int         ROM_AW      = 15,
  parameter int         HOLD_CYCLES = 1024,
  parameter logic [7:0] LOAD_INDEX  = 8'd1,
  parameter logic [9:0] RST_MASK    = RST_MASK_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic [9:0]        status_sw,
  output logic [9:0]        switch_out,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_data,
  input  logic              rom_ready,
  output logic              core_reset,
  output logic              rom_valid,
  output logic              load_err
);
  localparam int CW = $clog2(HOLD_CYCLES);
  boot_state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_dl, r_got, w_got, r_valid, w_valid, r_err, w_err;
  logic [9:0] r_sw;
  logic w_start, w_in_range, w_load, w_full, w_cnt_end;
  assign w_start    = ioctl_download & ~r_dl & (ioctl_index == LOAD_INDEX);
  assign w_in_range = (ioctl_addr >> ROM_AW) == '0;
  assign w_load     = (r_state == S_LOAD) & ioctl_wr & ~w_full & w_in_range;
  assign w_cnt_end  = r_cnt == CW'(HOLD_CYCLES - 1);
  pc8001m_wbuf #(.AW(ROM_AW)) u_wbuf (
    .clk(clk_sys),
    .rst(reset),
    .i_load(w_load),
    .i_addr(ioctl_addr[ROM_AW-1:0]),
    .i_data(ioctl_dout),
    .i_ready(rom_ready),
    .o_full(w_full),
    .o_addr(rom_addr),
    .o_data(rom_data)
  );
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_got   = r_got;
    w_valid = r_valid;
    w_err   = r_err;
    case (r_state)
      S_HOLD: begin
        w_cnt = soft_reset ? '0 : w_cnt_end ? r_cnt : r_cnt + 1'b1;
        if (!soft_reset && w_cnt_end && r_valid) w_state = S_RUN;
      end
      S_LOAD: begin
        w_err = r_err | (ioctl_wr & ~w_load);
        w_got = r_got | w_load;
        if (!ioctl_download) w_state = S_DRAIN;
      end
      S_DRAIN:
        if (!w_full) begin
          w_valid = r_got;
          w_cnt   = '0;
          w_state = S_HOLD;
        end
      S_RUN:
        if (soft_reset || |((status_sw ^ r_sw) & RST_MASK)) begin
          w_cnt   = '0;
          w_state = S_HOLD;
        end
      default: w_state = S_HOLD;
    endcase
    if (w_start) begin
      w_state = S_LOAD;
      w_got   = 1'b0;
      w_valid = 1'b0;
      w_err   = 1'b0;
    end
  end
  // Reset-only switch bits are frozen while the core runs; everything else follows with one register stage.
  always_ff @(posedge clk_sys)
    if (reset) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_dl    <= 1'b0;
      r_got   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_sw    <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_dl    <= ioctl_download;
      r_got   <= w_got;
      r_valid <= w_valid;
      r_err   <= w_err;
      r_sw    <= r_state == S_RUN ? (r_sw & RST_MASK) | (status_sw & ~RST_MASK) : status_sw;
    end
  assign ioctl_wait = w_full;
  assign rom_we     = w_full;
  assign core_reset = r_state != S_RUN;
  assign rom_valid  = r_valid;
  assign load_err   = r_err;
  assign switch_out = r_sw;
endmodule

// File: tb/tb_pc8001m_boot_ctrl.sv
// tb_pc8001m_boot_ctrl: randomized scoreboard bench for pc8001m_boot_ctrl
module tb_pc8001m_boot_ctrl;
  localparam int HC = 1024;
  localparam logic [9:0] MASK = 10'b10_0001_0000;
  logic clk_sys = 0, reset = 1, soft_reset = 0, ioctl_download = 0, ioctl_wr = 0, rom_ready = 1;
  logic [7:0] ioctl_index = 0, ioctl_dout = 0, rom_data;
  logic [24:0] ioctl_addr = 0;
  logic [9:0] status_sw = 0, switch_out;
  logic ioctl_wait, rom_we, core_reset, rom_valid, load_err;
  logic [14:0] rom_addr;
  int checks = 0, failures = 0;
  bit slow = 0;
  logic [22:0] exp_q[$];
  always #5 clk_sys = ~clk_sys;
  pc8001m_boot_ctrl dut (
    .clk_sys(clk_sys), .reset(reset), .soft_reset(soft_reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .status_sw(status_sw), .switch_out(switch_out), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ready(rom_ready), .core_reset(core_reset),
    .rom_valid(rom_valid), .load_err(load_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask
  task automatic send(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    while (ioctl_wait && n < 200) begin
      tick();
      n++;
    end
    chk("wait_timeout", 32'(n < 200), 1);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1;
    if (a < 25'h8000) exp_q.push_back({a[14:0], d});
    tick();
    ioctl_wr = 0;
  endtask
  task automatic start_dl(input logic [7:0] idx);
    tick();
    ioctl_index = idx;
    ioctl_download = 1;
    tick();
  endtask
  task automatic end_dl;
    tick();
    ioctl_download = 0;
  endtask
  task automatic wait_valid;
    int n = 0;
    @(negedge clk_sys);
    while (!rom_valid && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    chk("rom_valid_after_drain", rom_valid, 1);
  endtask
  task automatic measure(input string name);
    int n = 0;
    while (core_reset && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    chk(name, n, HC);
  endtask
  initial begin
    int hc = 0;
    logic pw = 0;
    logic [22:0] pv = 0;
    forever begin
      @(negedge clk_sys);
      hc = rom_we ? hc + 1 : 0;
      rom_ready = !slow || hc > 5;
      if (reset) pw = 0;
      else begin
        chk("wait_eq_full", ioctl_wait, rom_we);
        if (pw) chk("hold_stable", {rom_addr, rom_data}, pv);
        if (rom_we && rom_ready) begin
          chk("write_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("rom_write", {rom_addr, rom_data}, exp_q.pop_front());
        end
        pw = rom_we && !rom_ready;
        pv = {rom_addr, rom_data};
      end
    end
  end
  initial begin
    repeat (3) tick();
    @(negedge clk_sys);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_rom_valid", rom_valid, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_switch_out", switch_out, 0);
    tick();
    reset = 0;
    repeat (5000) tick();
    @(negedge clk_sys);
    chk("idle_core_reset", core_reset, 1);
    chk("idle_rom_valid", rom_valid, 0);
    start_dl(1);
    for (int i = 0; i < 16; i++) begin
      send(25'(i), 8'($urandom));
      if (i == 0) begin
        @(negedge clk_sys);
        chk("first_we_t1", rom_we, 1);
        chk("first_wait_t1", ioctl_wait, 1);
        chk("first_addr_t1", rom_addr, 0);
      end
    end
    end_dl();
    wait_valid();
    measure("hold_after_load1");
    chk("load1_err", load_err, 0);
    chk("load1_queue_empty", exp_q.size(), 0);
    slow = 1;
    start_dl(1);
    @(negedge clk_sys);
    chk("load2_valid_cleared", rom_valid, 0);
    chk("load2_core_reset", core_reset, 1);
    for (int i = 0; i < 8; i++) send(25'($urandom_range(0, 32767)), 8'($urandom));
    end_dl();
    wait_valid();
    chk("load2_err", load_err, 0);
    chk("load2_queue_empty", exp_q.size(), 0);
    measure("hold_after_load2");
    start_dl(1);
    send(25'h7FFF, 8'($urandom));
    send(25'($urandom_range(0, 32767)), 8'($urandom));
    send(25'h8000, 8'($urandom));
    @(negedge clk_sys);
    chk("oor_no_we", rom_we, 0);
    chk("oor_load_err", load_err, 1);
    send(25'd5, 8'($urandom));
    ioctl_addr = 25'd6;
    ioctl_dout = 8'($urandom);
    ioctl_wr = 1;
    tick();
    ioctl_wr = 0;
    send(25'd7, 8'($urandom));
    send(25'h1FFFFFF, 8'($urandom));
    send(25'd8, 8'($urandom));
    end_dl();
    wait_valid();
    chk("load3_err", load_err, 1);
    chk("load3_queue_empty", exp_q.size(), 0);
    measure("hold_after_load3");
    slow = 0;
    tick();
    status_sw[0] = ~status_sw[0];
    tick();
    @(negedge clk_sys);
    chk("sw0_follow", switch_out, status_sw);
    chk("sw0_no_reset", core_reset, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      status_sw = (status_sw & MASK) | (10'($urandom) & ~MASK);
      tick();
      @(negedge clk_sys);
      chk("sw_rand_follow", switch_out, status_sw);
      chk("sw_rand_no_reset", core_reset, 0);
    end
    tick();
    status_sw[9] = ~status_sw[9];
    tick();
    @(negedge clk_sys);
    chk("sw9_reset_next", core_reset, 1);
    measure("hold_after_sw9");
    chk("sw9_applied", switch_out, status_sw);
    chk("sw9_run_again", core_reset, 0);
    start_dl(2);
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = 8'($urandom);
      ioctl_wr = 1;
      tick();
      ioctl_wr = 0;
      tick();
      @(negedge clk_sys);
      chk("idx2_core_reset", core_reset, 0);
      chk("idx2_rom_valid", rom_valid, 1);
    end
    end_dl();
    tick();
    soft_reset = 1;
    tick();
    soft_reset = 0;
    @(negedge clk_sys);
    chk("soft_core_reset", core_reset, 1);
    chk("soft_rom_valid", rom_valid, 1);
    measure("hold_after_soft");
    chk("soft_rom_valid_kept", rom_valid, 1);
    slow = 1;
    start_dl(1);
    @(negedge clk_sys);
    chk("load4_err_cleared", load_err, 0);
    send(25'd3, 8'($urandom));
    reset = 1;
    ioctl_download = 0;
    exp_q.delete();
    tick();
    reset = 0;
    @(negedge clk_sys);
    chk("rst_load_no_we", rom_we, 0);
    chk("rst_load_valid", rom_valid, 0);
    chk("rst_load_core_reset", core_reset, 1);
    repeat (20) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc8001m_boot_ctrl.md
# pc8001m_boot_ctrl

Boot and configuration sequencer between the MiSTer HPS I/O layer and the pc8001m core. It streams the BIND88 ROM image from the ioctl download port into the core's ROM write port with a one-entry buffer and `ioctl_wait` back-pressure. It holds the core in reset until a ROM image is present and for a fixed settle time after every load, soft reset or reset-class switch change. It also gates OSD switch changes, such as CPU mode and high-speed mode, that are only safe to apply while the core is in reset.

## Interface
Parameters:
- ROM_AW, 15: ROM write address width; image bytes at `ioctl_addr >= 2**ROM_AW` are dropped.
- HOLD_CYCLES, 1024: cycles `core_reset` stays high after the hold condition clears (≥2).
- LOAD_INDEX, 8'd1: `ioctl_index` value that selects the ROM image.
- RST_MASK, 10'b10_0001_0000: switch bits that may only change while the core is in reset (bit 9 high-speed, bit 4 CPU mode).

Ports:
- One clock; reset is synchronous and active-high.
- clk_sys  in  1  system clock.
- reset  in  1  power-on reset; clears all state, including `rom_valid`.
- soft_reset  in  1  OSD/button reset; forces HOLD and preserves `rom_valid`.
- ioctl_download  in  1  HPS download active.
- ioctl_index  in  8  download file index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure to HPS; registered, high while the buffer is full.
- status_sw  in  10  live switch vector from OSD status.
- switch_out  out  10  switch vector to the core `SW` input.
- rom_we  out  1  ROM write request; held until accepted.
- rom_addr  out  ROM_AW  write address.
- rom_data  out  8  write data.
- rom_ready  in  1  write accepted on any edge where `rom_we & rom_ready` is true.
- core_reset  out  1  active-high reset to the core.
- rom_valid  out  1  a non-empty image has been loaded.
- load_err  out  1  sticky flag: a byte was dropped. Cleared by `reset` or by the start of the next download.

## Operation
States are HOLD, LOAD, DRAIN and RUN.
- **HOLD**
  - `core_reset` = 1.
  - The counter increments each cycle.
  - RST_MASK bits of `switch_out` track `status_sw`.
  - Exit to RUN when count = HOLD_CYCLES−1, `rom_valid` = 1 and no hold condition is active. Otherwise the counter saturates.
- **LOAD**
  - Entered from any state on the rising edge of `ioctl_download` when `ioctl_index` = LOAD_INDEX. Entry clears `load_err`, `rom_valid` and the byte counter.
  - `core_reset` = 1.
  - An `ioctl_wr` with the buffer empty and `ioctl_addr < 2**ROM_AW` loads the buffer and increments the byte counter.
  - An out-of-range address drops the byte and sets `load_err`.
  - An `ioctl_wr` with the buffer full (protocol violation) drops the byte and sets `load_err`.
- **DRAIN**
  - Entered when `ioctl_download` falls.
  - Waits for the buffer to empty, then sets `rom_valid` = (byte counter ≠ 0), clears the hold counter and goes to HOLD.
- **RUN**
  - `core_reset` = 0.
  - Non-RST_MASK bits of `switch_out` follow `status_sw` with a one-cycle register delay.
  - If `(status_sw ^ switch_out) & RST_MASK` ≠ 0, or `soft_reset` = 1, go to HOLD with the counter cleared.
- Downloads with a different index are ignored in every state.
- `soft_reset` in HOLD restarts the counter. In LOAD or DRAIN it is ignored.

## Timing
- Reset values:
  - State is HOLD, counter 0.
  - `core_reset` = 1, `rom_we` = 0, `ioctl_wait` = 0.
  - `rom_valid` = 0, `load_err` = 0, `switch_out` = 0, buffer empty.
- `ioctl_wr` at edge t drives `rom_we`/`rom_addr`/`rom_data` valid from t+1, and `ioctl_wait` = 1 from t+1.
- With `rom_ready` tied high, the write completes at t+1 and `ioctl_wait` falls at t+2. Sustained throughput is one byte per 2 cycles.
- `rom_addr`/`rom_data` are stable while `rom_we` = 1 and `rom_ready` = 0.
- Leaving HOLD: `core_reset` falls exactly HOLD_CYCLES cycles after the last cycle on which a hold condition was true.
- A switch change in RUN raises `core_reset` on the next cycle.
- Simultaneous download start and switch change: LOAD wins.
- `reset` during LOAD drops the pending buffer entry with no `rom_we` after the reset edge. This leaves a partial image, and `rom_valid` = 0 until the next download.

## Structure
- Shared package `pc8001m_pkg` holds:
  - the state enum `boot_state_t`;
  - switch bit index constants `SW_GREEN`(0), `SW_BEEP`(2), `SW_FDC`(3), `SW_CPU`(4), `SW_PCG`(5), `SW_EXPROM`(7), `SW_HISPEED`(9);
  - the default RST_MASK.
- One sub-module, `pc8001m_wbuf`: the one-entry write buffer with valid/ready handshake and the full flag feeding `ioctl_wait`. The counter and FSM live in the top block.

## Test plan
- Reset, then no download for 5000 cycles -> `core_reset` stays 1, `rom_valid` = 0, `rom_we` never asserted.
- Download index 1, 16 bytes at addresses 0..15, `rom_ready` = 1 -> 16 `rom_we` pulses with matching address/data. `rom_valid` = 1 after DRAIN, and `core_reset` falls 1024 cycles later.
- `rom_ready` low for 5 cycles per write -> `ioctl_wait` stays high throughout, no byte lost or duplicated, `load_err` = 0.
- Byte at `ioctl_addr` = 0x8000 with ROM_AW = 15 -> no `rom_we` for it, `load_err` = 1, and the following in-range bytes are still written.
- In RUN, toggle `status_sw[9]` -> `core_reset` = 1 the next cycle, `switch_out[9]` updates during HOLD, and RUN resumes after 1024 cycles. Toggling `status_sw[0]` -> `switch_out[0]` follows one cycle later with no reset.
- Download with index 2 during RUN -> no state change. `soft_reset` pulse in RUN -> HOLD for 1024 cycles with `rom_valid` still 1.
